// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss interface: request field layout,
// line/word geometry and the responder FSM state encoding.
package cache_pkg;

  localparam int unsigned LINE_W        = 128;
  localparam int unsigned WORD_W        = 32;

  // Miss request layout: {line address, write flag, write line}
  localparam int unsigned MISS_REQ_W    = 149;
  localparam int unsigned MISS_WE_BIT   = LINE_W;
  localparam int unsigned MISS_ADDR_LO  = MISS_WE_BIT + 1;
  localparam int unsigned MISS_ADDR_HI  = MISS_REQ_W - 1;
  localparam int unsigned MISS_ADDR_W   = MISS_ADDR_HI - MISS_ADDR_LO + 1;

  typedef struct packed {
    logic [MISS_ADDR_W-1:0] addr;
    logic                   we;
    logic [LINE_W-1:0]      line;
  } miss_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RESP = 2'd2
  } miss_state_e;

endpackage

// File: rtl/cache_miss_responder.sv
// Memory-side responder for the cache miss port. Takes one line request at a
// time, runs it as four word beats on the backing-memory bus and returns a
// single-cycle response with the line (or echoed write line) or a bus error.
//
// Ports:
//   clock, reset_n                  clock, async active-low reset
//   req_valid_miss, req_info_miss   request strobe and {addr, we, line}
//   rsp_valid_miss, rsp_data_miss,
//   rsp_bus_error                   single-cycle response
//   mem_req/we/addr/wdata           beat request to backing memory
//   mem_ack/rdata/err               beat completion from backing memory
//   busy                            FSM not idle
//   proto_err                       sticky: request seen while not idle
module cache_miss_responder
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned MEM_LINES = 4096,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid_miss,
  input  logic [MISS_REQ_W-1:0] req_info_miss,
  output logic                  rsp_valid_miss,
  output logic [LINE_W-1:0]     rsp_data_miss,
  output logic                  rsp_bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W+1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_err,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  miss_req_t   req;
  logic [ADDR_W-1:0] req_addr;
  logic        req_oob;

  miss_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [1:0]  beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic        err_q, err_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [LINE_W-1:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [ADDR_W+1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        proto_q, proto_d;

  assign req      = miss_req_t'(req_info_miss);
  assign req_addr = ADDR_W'(req.addr);
  assign req_oob  = (64'(req_addr) >= 64'(MEM_LINES));

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wline_d     = wline_q;
    line_d      = line_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    err_d       = err_q;
    proto_d     = proto_q | (req_valid_miss && (state_q != ST_IDLE));

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_miss) begin
          addr_d  = req_addr;
          we_d    = req.we;
          wline_d = req.line;
          line_d  = '0;
          beat_d  = 2'd0;
          wait_d  = '0;
          err_d   = req_oob;
          state_d = req_oob ? ST_RESP : ST_BEAT;
        end
      end
      ST_BEAT: begin
        // Timeout wins: mem_req is already low in this cycle
        if (wait_q == WAIT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (mem_err) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (mem_ack) begin
          // Beat b occupies line bits [b*32 +: 32]
          if (!we_q) begin
            line_d[{beat_q, 5'd0} +: WORD_W] = mem_rdata;
          end
          if (beat_q == 2'd3) begin
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            beat_d = 2'(beat_q + 2'd1);
            wait_d = '0;
          end
        end else begin
          wait_d = WAIT_W'(wait_q + 1'b1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from next-state values so they line up with state_q
    busy_d      = (state_d != ST_IDLE);
    mem_req_d   = (state_d == ST_BEAT) && (wait_d != WAIT_W'(TIMEOUT));
    mem_we_d    = (state_d == ST_BEAT) && we_d;
    mem_addr_d  = (state_d == ST_BEAT) ? {addr_d, beat_d} : '0;
    mem_wdata_d = ((state_d == ST_BEAT) && we_d) ? wline_d[{beat_d, 5'd0} +: WORD_W] : '0;
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = (state_d == ST_RESP) && err_d;
    rsp_data_d  = ((state_d == ST_RESP) && !err_d) ? (we_d ? wline_d : line_d) : '0;
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wline_q     <= '0;
      line_q      <= '0;
      beat_q      <= 2'd0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      proto_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wline_q     <= wline_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      proto_q     <= proto_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_miss = rsp_valid_q;
  assign rsp_data_miss  = rsp_data_q;
  assign rsp_bus_error  = rsp_err_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign busy           = busy_q;
  assign proto_err      = proto_q;

endmodule

// File: tb/tb_cache_miss_responder.sv
// Self-checking bench for cache_miss_responder: directed scenarios plus
// randomized transactions against a line-level reference model.
module tb_cache_miss_responder;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid_miss = 1'b0;
  logic [148:0]  req_info_miss = '0;
  logic          rsp_valid_miss;
  logic [127:0]  rsp_data_miss;
  logic          rsp_bus_error;
  logic          mem_req;
  logic          mem_we;
  logic [21:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_err = 1'b0;
  logic          busy;
  logic          proto_err;

  int errors = 0;
  int checks = 0;

  cache_miss_responder #(.ADDR_W(20), .MEM_LINES(4096), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_miss(req_valid_miss), .req_info_miss(req_info_miss),
    .rsp_valid_miss(rsp_valid_miss), .rsp_data_miss(rsp_data_miss),
    .rsp_bus_error(rsp_bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [31:0] wd;
  } beat_t;

  logic [31:0] mem_img [0:255];
  int          wait_cfg = 0;
  bit          never_ack = 1'b0;
  bit          err_en = 1'b0;
  logic [1:0]  err_beat = 2'd0;

  beat_t       acked_q[$];
  logic [21:0] req_addr_q[$];
  int          stab_err = 0;
  int          waited = 0;
  bit          prev_req = 1'b0;
  bit          prev_done = 1'b0;
  logic [54:0] prev_bus = '0;

  // Responds on the falling edge so the DUT samples ack/err on the next rising edge
  always @(negedge clock) begin
    if (!reset_n) begin
      mem_ack = 1'b0; mem_err = 1'b0; waited = 0; prev_req = 1'b0;
    end else if (mem_req) begin
      req_addr_q.push_back(mem_addr);
      if (prev_req && !prev_done && ({mem_we, mem_addr, mem_wdata} != prev_bus))
        stab_err++;
      prev_bus = {mem_we, mem_addr, mem_wdata};
      prev_req = 1'b1;
      mem_rdata = $urandom;
      if (never_ack) begin
        mem_ack = 1'b0; mem_err = 1'b0; prev_done = 1'b0;
      end else if (waited == wait_cfg) begin
        if (err_en && mem_addr[1:0] == err_beat) begin
          mem_err = 1'b1; mem_ack = 1'b0;
        end else begin
          mem_ack = 1'b1; mem_err = 1'b0;
          mem_rdata = mem_img[mem_addr[7:0]];
          acked_q.push_back('{we: mem_we, addr: mem_addr, wd: mem_wdata});
        end
        waited = 0; prev_done = 1'b1;
      end else begin
        mem_ack = 1'b0; mem_err = 1'b0; waited++; prev_done = 1'b0;
      end
    end else begin
      mem_ack = 1'b0; mem_err = 1'b0; waited = 0; prev_req = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [127:0] ref_read_line(input logic [19:0] a);
    logic [127:0] l;
    logic [7:0]   idx;
    for (int b = 0; b < 4; b++) begin
      idx = {a[5:0], 2'(b)};
      l[b*32 +: 32] = mem_img[idx];
    end
    return l;
  endfunction

  function automatic int ref_latency(input logic [19:0] a, input int w);
    if (a >= 20'd4096) return 1;
    return 1 + 4 * (w + 1);
  endfunction

  // Issue one request and wait (bounded) for the response
  task automatic run_txn(input logic [19:0] a, input logic we, input logic [127:0] line,
                         output int lat, output logic [127:0] data, output logic berr,
                         output logic rsp_after);
    @(negedge clock);
    req_valid_miss = 1'b1;
    req_info_miss  = {a, we, line};
    @(posedge clock); #1;
    req_valid_miss = 1'b0;
    req_info_miss  = '0;
    lat = 1;
    while (!rsp_valid_miss && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!rsp_valid_miss) lat = -1;
    data = rsp_data_miss;
    berr = rsp_bus_error;
    @(posedge clock); #1;
    rsp_after = rsp_valid_miss;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({rsp_valid_miss, rsp_bus_error, mem_req, mem_we, busy, proto_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {rsp_valid_miss, rsp_bus_error, mem_req, mem_we, busy, proto_err});
    end
    checks++;
    if (rsp_data_miss !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h addr=%h wdata=%h want 0", rsp_data_miss, mem_addr, mem_wdata);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_read_basic;
    int lat; logic [127:0] d; logic be, ra; int s0;
    mem_img[8'h40] = 32'h11111111; mem_img[8'h41] = 32'h22222222;
    mem_img[8'h42] = 32'h33333333; mem_img[8'h43] = 32'h44444444;
    wait_cfg = 0;
    s0 = acked_q.size();
    run_txn(20'h00010, 1'b0, '0, lat, d, be, ra);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL read_latency: got %0d want 5", lat); end
    checks++;
    if (d !== 128'h44444444_33333333_22222222_11111111 || be !== 1'b0) begin
      errors++; $display("FAIL read_data: got %h err=%b want 44444444333333332222222211111111 err=0", d, be);
    end
    checks++;
    if (acked_q.size() - s0 != 4 || acked_q[s0].addr !== 22'h40 || acked_q[s0+3].addr !== 22'h43) begin
      errors++; $display("FAIL read_addrs: beats=%0d first=%h want 4 beats 40..43", acked_q.size() - s0,
                         (acked_q.size() > s0) ? acked_q[s0].addr : 22'h3fffff);
    end
    checks++;
    if (ra !== 1'b0) begin errors++; $display("FAIL read_rsp_width: rsp_valid still %b want 0", ra); end
  endtask

  task automatic test_write_waits;
    int lat; logic [127:0] d; logic be, ra; int s0; int bad;
    logic [127:0] line;
    line = {4{32'hDEADBEEF}};
    wait_cfg = 2;
    s0 = acked_q.size();
    run_txn(20'h00002, 1'b1, line, lat, d, be, ra);
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL write_latency: got %0d want 13", lat); end
    checks++;
    if (d !== line || be !== 1'b0) begin
      errors++; $display("FAIL write_echo: got %h err=%b want %h err=0", d, be, line);
    end
    bad = (acked_q.size() - s0 == 4) ? 0 : 1;
    for (int b = 0; b < 4 && bad == 0; b++)
      if (acked_q[s0+b].addr !== 22'(8 + b) || acked_q[s0+b].we !== 1'b1 ||
          acked_q[s0+b].wd !== 32'hDEADBEEF) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL write_beats: %0d bad beats want 0", bad); end
    wait_cfg = 0;
  endtask

  task automatic test_out_of_range;
    int lat; logic [127:0] d; logic be, ra; int r0;
    r0 = req_addr_q.size();
    run_txn(20'h01000, 1'b0, '0, lat, d, be, ra);
    checks++;
    if (lat !== 1 || be !== 1'b1 || d !== '0) begin
      errors++; $display("FAIL oob_rsp: lat=%0d err=%b data=%h want lat=1 err=1 data=0", lat, be, d);
    end
    checks++;
    if (req_addr_q.size() != r0) begin
      errors++; $display("FAIL oob_no_memreq: got %0d mem_req cycles want 0", req_addr_q.size() - r0);
    end
  endtask

  task automatic test_mem_err;
    int lat; logic [127:0] d; logic be, ra; int r0; int saw3;
    err_en = 1'b1; err_beat = 2'd2;
    r0 = req_addr_q.size();
    run_txn(20'h00033, 1'b0, '0, lat, d, be, ra);
    err_en = 1'b0;
    checks++;
    if (lat !== 4 || be !== 1'b1 || d !== '0) begin
      errors++; $display("FAIL err_rsp: lat=%0d err=%b data=%h want lat=4 err=1 data=0", lat, be, d);
    end
    saw3 = 0;
    for (int i = r0; i < req_addr_q.size(); i++) if (req_addr_q[i][1:0] == 2'd3) saw3++;
    checks++;
    if (saw3 != 0 || req_addr_q.size() - r0 != 3) begin
      errors++; $display("FAIL err_abandon: beat3 reqs=%0d req cycles=%0d want 0 and 3", saw3, req_addr_q.size() - r0);
    end
  endtask

  task automatic test_timeout_proto;
    int lat; int r0; int s0; int extra;
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b want 0", proto_err); end
    never_ack = 1'b1;
    r0 = req_addr_q.size();
    s0 = acked_q.size();
    @(negedge clock);
    req_valid_miss = 1'b1;
    req_info_miss  = {20'h00021, 1'b0, 128'h0};
    @(posedge clock); #1;
    req_valid_miss = 1'b0;
    lat = 1;
    while (!rsp_valid_miss && lat < 200) begin
      @(negedge clock);
      req_valid_miss = (lat == 5);
      req_info_miss  = (lat == 5) ? {20'h00022, 1'b0, 128'h0} : '0;
      @(posedge clock); #1;
      req_valid_miss = 1'b0;
      lat++;
    end
    checks++;
    if (lat !== 17 || rsp_bus_error !== 1'b1 || rsp_data_miss !== '0) begin
      errors++; $display("FAIL timeout_rsp: lat=%0d err=%b data=%h want lat=17 err=1 data=0",
                         lat, rsp_bus_error, rsp_data_miss);
    end
    checks++;
    if (req_addr_q.size() - r0 != 15) begin
      errors++; $display("FAIL timeout_hold: mem_req cycles=%0d want 15", req_addr_q.size() - r0);
    end
    extra = 0;
    repeat (10) begin @(posedge clock); #1; if (rsp_valid_miss || busy) extra++; end
    never_ack = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || extra != 0 || acked_q.size() != s0) begin
      errors++; $display("FAIL proto_drop: proto_err=%b extra=%0d want proto_err=1 extra=0", proto_err, extra);
    end
  endtask

  task automatic test_reset_midflight;
    int lat; logic [127:0] d; logic be, ra; int extra;
    wait_cfg = 1;
    @(negedge clock);
    req_valid_miss = 1'b1;
    req_info_miss  = {20'h00005, 1'b0, 128'h0};
    @(posedge clock); #1;
    req_valid_miss = 1'b0;
    req_info_miss  = '0;
    repeat (2) begin @(posedge clock); #1; end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 22'h15) begin
      errors++; $display("FAIL rst_beat1: mem_req=%b addr=%h want 1 15", mem_req, mem_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL rst_async: mem_req=%b busy=%b proto=%b want 000", mem_req, busy, proto_err);
    end
    extra = 0;
    repeat (3) begin @(posedge clock); #1; if (rsp_valid_miss) extra++; end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin @(posedge clock); #1; if (rsp_valid_miss || mem_req) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL rst_discard: %0d stray cycles want 0", extra); end
    wait_cfg = 0;
    run_txn(20'h00010, 1'b0, '0, lat, d, be, ra);
    checks++;
    if (lat !== 5 || be !== 1'b0 || d !== ref_read_line(20'h00010)) begin
      errors++; $display("FAIL rst_recover: lat=%0d err=%b data=%h want 5 0 %h", lat, be, d, ref_read_line(20'h00010));
    end
  endtask

  task automatic test_random;
    int lat, elat, s0, bad; logic [127:0] d, ed, line; logic be, ra, we; logic [19:0] a; int w;
    for (int n = 0; n < 12; n++) begin
      a    = ($urandom_range(0, 4) == 0) ? 20'(4096 + $urandom_range(0, 300)) : 20'($urandom_range(0, 4095));
      we   = 1'($urandom_range(0, 1));
      line = {$urandom, $urandom, $urandom, $urandom};
      w    = $urandom_range(0, 3);
      wait_cfg = w;
      s0 = acked_q.size();
      run_txn(a, we, line, lat, d, be, ra);
      elat = ref_latency(a, w);
      ed   = (a >= 20'd4096) ? 128'h0 : (we ? line : ref_read_line(a));
      checks++;
      if (lat !== elat || d !== ed || be !== (a >= 20'd4096) || ra !== 1'b0) begin
        errors++; $display("FAIL rand_rsp[%0d]: a=%h we=%b w=%0d lat=%0d err=%b data=%h want lat=%0d data=%h",
                           n, a, we, w, lat, be, d, elat, ed);
      end
      bad = 0;
      if (a < 20'd4096) begin
        if (acked_q.size() - s0 != 4) bad = 1;
        for (int b = 0; b < 4 && bad == 0; b++)
          if (acked_q[s0+b].addr !== {a, 2'(b)} || acked_q[s0+b].we !== we ||
              (we && acked_q[s0+b].wd !== line[b*32 +: 32])) bad++;
      end else if (acked_q.size() != s0) bad = 1;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_beats[%0d]: a=%h we=%b bad=%0d want 0", n, a, we, bad); end
    end
    wait_cfg = 0;
  endtask

  task automatic test_bus_stability;
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bus_stable: %0d changes while mem_req held want 0", stab_err); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
    test_reset();
    test_read_basic();
    test_write_waits();
    test_out_of_range();
    test_mem_err();
    test_random();
    test_timeout_proto();
    test_reset_midflight();
    test_bus_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_miss_responder.md
# cache_miss_responder

Memory-side responder for the cache miss interface. Accepts one line-sized miss request at a time from a cache (instruction or data), performs it as four 32-bit beats on a word-wide backing-memory bus, and returns a single-cycle response carrying the 128-bit line or a bus-error flag. Sits between a cache's miss port and the on-chip memory or bus bridge.

## Interface
- `ADDR_W`, default 20: line-address width of the miss request.
- `MEM_LINES`, default 4096: number of implemented lines. A line address ≥ `MEM_LINES` is a bus error.
- `TIMEOUT`, default 15: maximum cycles a beat waits for `mem_ack`/`mem_err` before a bus error is declared.
- `clock` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid_miss` in 1: single-cycle request strobe.
- `req_info_miss` in 149: request fields.
  - [148:129] line address.
  - [128] write flag (1 = write).
  - [127:0] write line.
- `rsp_valid_miss` out 1: single-cycle response strobe.
- `rsp_data_miss` out 128: read line, or echo of the written line.
- `rsp_bus_error` out 1: qualifies `rsp_valid_miss`.
- `mem_req` out 1: beat request, held until acked or errored.
- `mem_we` out 1: beat is a write.
- `mem_addr` out ADDR_W+2: word address {line address, beat[1:0]}.
- `mem_wdata` out 32: write word.
- `mem_ack` in 1: beat complete.
- `mem_rdata` in 32: read word, valid with `mem_ack`.
- `mem_err` in 1: beat failed. It takes priority over `mem_ack` in the same cycle.
- `busy` out 1: high in every state except IDLE.
- `proto_err` out 1: sticky flag, set when a request arrives while not IDLE. Cleared only by reset.

## Operation
- FSM states: IDLE, BEAT, RESP.
- **IDLE**
  - On `req_valid_miss`, latch address, write flag and line.
  - Clear the beat counter and the assembled line.
  - If address ≥ `MEM_LINES`: go to RESP with error set. No `mem_req` is issued.
  - Otherwise go to BEAT.
- **BEAT**
  - `mem_req`=1 and `mem_addr`={addr, beat}.
  - On a write, `mem_wdata` = latched line[beat*32 +: 32].
  - On `mem_ack` for a read, store `mem_rdata` into line[beat*32 +: 32].
  - On `mem_ack` with beat==3, go to RESP with no error. Otherwise increment beat and reset the wait counter.
  - On `mem_err`, go to RESP with error; the remaining beats are abandoned.
  - If the wait counter reaches `TIMEOUT` with no ack or error, go to RESP with error and deassert `mem_req`.
- **RESP**
  - `rsp_valid_miss`=1 for exactly one cycle.
  - `rsp_data_miss` carries the assembled read line, or the latched line for a write. On error it is zero.
  - Next state is IDLE.
- A request strobe in BEAT or RESP is dropped and sets `proto_err`. The requester guarantees only one request is outstanding.
- A request in the same cycle as RESP is also dropped. New requests are accepted only in IDLE.
- Beat 0 maps to line bits [31:0]; beat 3 maps to [127:96].

## Timing
- Reset (asynchronous assert) forces all outputs to 0 and the FSM to IDLE.
  - A transfer in flight is discarded; no response is issued after reset.
  - `mem_req` drops immediately on reset assertion.
- Request accepted at cycle T with zero-wait memory:
  - Beats occupy T+1 to T+4.
  - `rsp_valid_miss` is high at T+5.
- Each memory wait state adds one cycle to the latency.
- Out-of-range request at T: `rsp_valid_miss`=1 with `rsp_bus_error`=1 at T+1.
- Timeout: a beat starting at cycle B errors at B+`TIMEOUT`; the response follows one cycle later.
- `mem_addr`, `mem_we` and `mem_wdata` are stable for as long as `mem_req` is high.
- Earliest next acceptance is the cycle after RESP.

## Structure
- Shared `cache_pkg`:
  - Field offsets and width of the miss request (149, 148:129, 128, 127:0).
  - `LINE_W`=128 and `WORD_W`=32.
  - FSM state enum.
  - This package is shared with the cache miss-request producers.
- Single flat module; no sub-module.
- Internal registers:
  - 2-bit beat counter.
  - Wait counter sized to hold `TIMEOUT`.
  - 128-bit assembly register.

## Test plan
- Read, addr 0x00010, zero-wait memory returning words 0x11111111..0x44444444 -> `mem_addr` 0x40..0x43; `rsp_data_miss`=0x44444444_33333333_22222222_11111111 at T+5; `rsp_bus_error`=0.
- Write, addr 0x00002, line 0xDEADBEEF repeated, 2 wait states per beat -> four write beats at word addresses 0x8..0xB; response at T+13 echoing the line; no error.
- Read, addr 0x01000 (= `MEM_LINES`) -> no `mem_req`; `rsp_valid_miss` with `rsp_bus_error`=1 at T+1.
- Read with `mem_err` on beat 2 -> beat 3 is never requested; error response with data 0 the cycle after the error.
- Read, memory never acks -> `mem_req` held 15 cycles, then an error response; a second `req_valid_miss` during the wait sets `proto_err` and is not served.
- `reset_n` pulled low during beat 1 -> `mem_req` and `busy` go low immediately; no `rsp_valid_miss`; a new request after release completes normally.
